// File: rtl/counter_sched.sv
// counter_sched: write-port sequencer for the Counter_x timer.
// Arbitrates between CPU writes and channel-0 auto-reload, and raises the timeout irq.
//
// Ports:
//   clk, rst             clock; synchronous active-low reset
//   cpu_req/ch/val       CPU write request, held until cpu_ack
//   cpu_ack              1-cycle grant pulse, aligned with the CPU's counter_we
//   auto_en/auto_period  channel-0 auto-reload enable and reload value
//   counter0_OUT         channel-0 terminal flag, asynchronous to clk
//   counter_we/ch/val    registered write strobe, channel and data to the counter
//   irq, irq_clr         sticky timeout interrupt and its clear pulse
//   ovf                  sticky flag: timeout arrived while a reload was still pending
//   busy                 high whenever the sequencer is not idle
module counter_sched #(
  parameter int GAP         = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [1:0]  cpu_ch,
  input  logic [31:0] cpu_val,
  output logic        cpu_ack,
  input  logic        auto_en,
  input  logic [31:0] auto_period,
  input  logic        counter0_OUT,
  output logic        counter_we,
  output logic [1:0]  counter_ch,
  output logic [31:0] counter_val,
  output logic        irq,
  input  logic        irq_clr,
  output logic        ovf,
  output logic        busy
);

  if (GAP < 1 || GAP > 15) begin : g_bad_gap
    $error("counter_sched: GAP must be 1..15");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("counter_sched: SYNC_STAGES must be 2..4");
  end

  localparam logic [3:0] GAP_LD = 4'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_GAP
  } state_t;

  typedef enum logic {
    G_CPU,
    G_AUTO
  } grant_t;

  state_t state;
  state_t state_n;
  grant_t last_grant;
  grant_t last_grant_n;

  logic [3:0] gap_cnt;
  logic [3:0] gap_cnt_n;

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_prev;
  logic                   tick;

  logic auto_pend;
  logic grant_cpu;
  logic grant_auto;

  logic        we_n;
  logic        ack_n;
  logic [1:0]  ch_n;
  logic [31:0] val_n;

  // Synchroniser; tick marks a rising edge of the synchronised flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync      <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], counter0_OUT};
      sync_prev <= sync[SYNC_STAGES-1];
    end
  end

  assign tick = sync[SYNC_STAGES-1] & ~sync_prev;

  // Winner selection, only meaningful in IDLE.
  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant_cpu  = 1'b0;
    grant_auto = 1'b0;
    if (state == S_IDLE) begin
      case ({cpu_req, auto_pend})
        2'b10: grant_cpu = 1'b1;
        2'b01: grant_auto = 1'b1;
        2'b11: begin
          if (last_grant == G_AUTO) grant_cpu = 1'b1;
          else grant_auto = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    gap_cnt_n    = gap_cnt;
    we_n         = 1'b0;
    ack_n        = 1'b0;
    ch_n         = counter_ch;
    val_n        = counter_val;
    unique case (state)
      S_IDLE: begin
        unique case (1'b1)
          grant_cpu: begin
            state_n      = S_WRITE;
            we_n         = 1'b1;
            ack_n        = 1'b1;
            ch_n         = cpu_ch;
            val_n        = cpu_val;
            last_grant_n = G_CPU;
          end
          grant_auto: begin
            state_n      = S_WRITE;
            we_n         = 1'b1;
            ch_n         = 2'd0;
            val_n        = auto_period;
            last_grant_n = G_AUTO;
          end
          default: ;
        endcase
      end
      S_WRITE: begin
        state_n   = S_GAP;
        gap_cnt_n = GAP_LD;
      end
      S_GAP: begin
        if (gap_cnt == 4'd0) state_n = S_IDLE;
        else gap_cnt_n = gap_cnt - 4'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      last_grant <= G_AUTO;
      gap_cnt    <= 4'd0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      gap_cnt    <= gap_cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      counter_we  <= 1'b0;
      cpu_ack     <= 1'b0;
      counter_ch  <= 2'd0;
      counter_val <= 32'd0;
      busy        <= 1'b0;
    end else begin
      counter_we  <= we_n;
      cpu_ack     <= ack_n;
      counter_ch  <= ch_n;
      counter_val <= val_n;
      busy        <= (state_n != S_IDLE);
    end
  end

  // A tick arriving on the same cycle the old request is granted
  // queues a fresh request rather than flagging an overrun.
  always_ff @(posedge clk) begin
    if (!rst) begin
      auto_pend <= 1'b0;
      ovf       <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (!auto_en) auto_pend <= 1'b0;
      else if (tick) auto_pend <= 1'b1;
      else if (grant_auto) auto_pend <= 1'b0;

      if (tick && auto_en && auto_pend && !grant_auto) ovf <= 1'b1;

      if (tick) irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: directed bench for counter_sched.
// Expected writes are queued with their due cycle and checked as they appear.
module tb_counter_sched;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic [1:0]  cpu_ch;
  logic [31:0] cpu_val;
  logic        cpu_ack;
  logic        auto_en;
  logic [31:0] auto_period;
  logic        counter0_OUT;
  logic        counter_we;
  logic [1:0]  counter_ch;
  logic [31:0] counter_val;
  logic        irq;
  logic        irq_clr;
  logic        ovf;
  logic        busy;

  counter_sched dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_ch       (cpu_ch),
    .cpu_val      (cpu_val),
    .cpu_ack      (cpu_ack),
    .auto_en      (auto_en),
    .auto_period  (auto_period),
    .counter0_OUT (counter0_OUT),
    .counter_we   (counter_we),
    .counter_ch   (counter_ch),
    .counter_val  (counter_val),
    .irq          (irq),
    .irq_clr      (irq_clr),
    .ovf          (ovf),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [1:0]  ch;
    logic [31:0] val;
    logic        ack;
  } wr_t;

  wr_t sb[$];
  int  n_vec;
  int  n_err;
  int  cyc;
  int  n_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input logic [1:0] ch, input logic [31:0] val, input logic ack);
    wr_t e;
    e.cyc = c;
    e.ch  = ch;
    e.val = val;
    e.ack = ack;
    sb.push_back(e);
  endtask

  // One clock; sample 1ns after the edge, score any write, then drop cpu_req on ack.
  task automatic step();
    wr_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (counter_we === 1'b1) begin
      n_wr++;
      if (sb.size() == 0) begin
        chk("unexpected_we", 32'(cyc), 32'hffff_ffff);
      end else begin
        e = sb.pop_front();
        chk("wr_cyc", 32'(cyc), 32'(e.cyc));
        chk("wr_ch", 32'(counter_ch), 32'(e.ch));
        chk("wr_val", counter_val, e.val);
        chk("wr_ack", 32'(cpu_ack), 32'(e.ack));
      end
    end else begin
      chk("ack_without_we", 32'(cpu_ack), 32'd0);
    end
    if (cpu_ack === 1'b1) cpu_req = 1'b0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    int bc;
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    n_wr  = 0;
    rst          = 1'b0;
    cpu_req      = 1'b1;
    cpu_ch       = 2'd3;
    cpu_val      = 32'hdead_beef;
    auto_en      = 1'b0;
    auto_period  = 32'd0;
    counter0_OUT = 1'b0;
    irq_clr      = 1'b0;

    // Reset held 3 cycles with a pending CPU request.
    run_to(3);
    chk("rst_we", 32'(counter_we), 32'd0);
    chk("rst_ack", 32'(cpu_ack), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ch", 32'(counter_ch), 32'd0);
    chk("rst_val", counter_val, 32'd0);
    rst     = 1'b1;
    cpu_req = 1'b0;
    run_to(4);
    chk("idle_busy", 32'(busy), 32'd0);

    // Single CPU write; busy for 1+GAP cycles.
    cpu_req = 1'b1;
    cpu_ch  = 2'd2;
    cpu_val = 32'h0000_1234;
    push(5, 2'd2, 32'h0000_1234, 1'b1);
    run_to(5);
    bc = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy === 1'b1) bc++;
      step();
    end
    chk("busy_len", 32'(bc), 32'd5);

    // Auto reload from a counter0_OUT rising edge.
    auto_en      = 1'b1;
    auto_period  = 32'd100;
    counter0_OUT = 1'b1;
    push(21, 2'd0, 32'd100, 1'b0);
    run_to(19);
    chk("irq_before", 32'(irq), 32'd0);
    run_to(20);
    chk("irq_rise", 32'(irq), 32'd1);
    run_to(30);
    chk("ovf_single", 32'(ovf), 32'd0);
    irq_clr = 1'b1;
    run_to(31);
    chk("irq_clr", 32'(irq), 32'd0);
    irq_clr = 1'b0;

    // Re-reset, then a genuine tie: CPU wins first, AUTO wins the next tie.
    rst          = 1'b0;
    counter0_OUT = 1'b0;
    run_to(32);
    rst = 1'b1;
    run_to(33);
    counter0_OUT = 1'b1;
    run_to(36);
    cpu_req = 1'b1;
    cpu_ch  = 2'd1;
    cpu_val = 32'h55;
    push(37, 2'd1, 32'h55, 1'b1);
    run_to(38);
    cpu_req = 1'b1;
    cpu_ch  = 2'd1;
    cpu_val = 32'h66;
    push(43, 2'd0, 32'd100, 1'b0);
    push(49, 2'd1, 32'h66, 1'b1);
    run_to(55);
    chk("tie_ovf", 32'(ovf), 32'd0);
    chk("tie_drain", 32'(sb.size()), 32'd0);

    // irq_clr coincident with a new edge: set wins.
    counter0_OUT = 1'b0;
    run_to(58);
    counter0_OUT = 1'b1;
    run_to(60);
    irq_clr = 1'b1;
    push(62, 2'd0, 32'd100, 1'b0);
    run_to(61);
    chk("irq_set_wins", 32'(irq), 32'd1);
    irq_clr      = 1'b0;
    counter0_OUT = 1'b0;
    run_to(67);
    irq_clr = 1'b1;
    run_to(68);
    chk("irq_clr_alone", 32'(irq), 32'd0);
    irq_clr = 1'b0;

    // Overrun: two edges while the CPU write holds the FSM in GAP.
    cpu_req      = 1'b1;
    cpu_ch       = 2'd3;
    cpu_val      = 32'h0000_00a5;
    counter0_OUT = 1'b1;
    push(69, 2'd3, 32'h0000_00a5, 1'b1);
    push(75, 2'd0, 32'd100, 1'b0);
    run_to(69);
    counter0_OUT = 1'b0;
    run_to(70);
    counter0_OUT = 1'b1;
    run_to(72);
    chk("ovf_before", 32'(ovf), 32'd0);
    run_to(73);
    chk("ovf_set", 32'(ovf), 32'd1);
    run_to(90);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    chk("final_drain", 32'(sb.size()), 32'd0);
    chk("write_count", 32'(n_wr), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
